// File: rtl/cdc_hs_rx.sv
// Receiver side of a 4-phase req/ack clock-domain crossing with a valid/ready output.
// Define CDC_HS_RX_SYNC3_EN to use a 3-flop request synchronizer instead of 2.
module cdc_hs_rx #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ack_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [15:0]       xfer_cnt_o
);

`ifdef CDC_HS_RX_SYNC3_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        ACK   = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] reqSync_q;
    logic                   reqSync;
    logic [DATA_W-1:0]      dataOut_q, dataOut_d;
    logic [15:0]            xferCnt_q, xferCnt_d;
    logic                   ack_q, ack_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;

    // Only these flops ever see req_i; everything else uses the synchronized copy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reqSync_q <= '0;
        end else begin
            reqSync_q <= {reqSync_q[SYNC_STAGES-2:0], req_i};
        end
    end

    assign reqSync = reqSync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            dataOut_q <= '0;
            xferCnt_q <= '0;
            ack_q     <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dataOut_q <= dataOut_d;
            xferCnt_q <= xferCnt_d;
            ack_q     <= ack_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (reqSync)  state_d = VALID;
            VALID:   if (ready_i)  state_d = ACK;
            ACK:     if (!reqSync) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ack/valid are registered from the next state so both leave the block straight from flops.
    always_comb begin
        dataOut_d = dataOut_q;
        xferCnt_d = xferCnt_q;
        err_d     = err_q;
        ack_d     = (state_d == ACK);
        valid_d   = (state_d == VALID);
        if (state_q == IDLE && reqSync) begin
            dataOut_d = data_i;
        end
        if (state_q == VALID && ready_i) begin
            xferCnt_d = xferCnt_q + 16'd1;
        end
        if (state_q == VALID && !reqSync) begin
            err_d = 1'b1;
        end
    end

    assign ack_o      = ack_q;
    assign valid_o    = valid_q;
    assign data_o     = dataOut_q;
    assign busy_o     = (state_q != IDLE);
    assign err_o      = err_q;
    assign xfer_cnt_o = xferCnt_q;

endmodule

// File: tb/tb_cdc_hs_rx.sv
// Scoreboard bench for cdc_hs_rx: a sender model drives 4-phase handshakes, a monitor checks delivered words.
// Expected latency follows CDC_HS_RX_SYNC3_EN when the bench is built with it.
module tb_cdc_hs_rx;

    localparam int DATA_W = 8;
`ifdef CDC_HS_RX_SYNC3_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              req_i;
    logic [DATA_W-1:0] data_i;
    logic              ack_o;
    logic              valid_o;
    logic              ready_i;
    logic [DATA_W-1:0] data_o;
    logic              busy_o;
    logic              err_o;
    logic [15:0]       xfer_cnt_o;

    int                errors = 0;
    int                checks = 0;
    logic [DATA_W-1:0] expQ[$];
    logic [15:0]       modelCount = 16'd0;
    bit                pendingAck = 1'b0;
    bit                randReady = 1'b0;
    logic              readyLevel = 1'b1;

    cdc_hs_rx #(.DATA_W(DATA_W)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .data_i     (data_i),
        .ack_o      (ack_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .busy_o     (busy_o),
        .err_o      (err_o),
        .xfer_cnt_o (xfer_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic sigNow(input int sel);
        case (sel)
            0:       return valid_o;
            1:       return ack_o;
            default: return busy_o;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic waitSig(input int sel, input logic level, input int maxCyc, input string name,
                           output int cycles);
        cycles = 0;
        while (sigNow(sel) !== level && cycles < maxCyc) begin
            tick();
            cycles++;
        end
        if (sigNow(sel) !== level) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout %s: waited %0d cycles, signal is %b, expected %b",
                     name, cycles, sigNow(sel), level);
        end
    endtask

    // One sender transaction; with dropEarly the sender violates the protocol by dropping req during VALID.
    task automatic applyStimulus(input logic [DATA_W-1:0] word, input bit dropEarly);
        int c;
        expQ.push_back(word);
        data_i = word;
        req_i  = 1'b1;
        if (!dropEarly) begin
            waitSig(1, 1'b1, 300, "ackRise", c);
            req_i  = 1'b0;
            data_i = DATA_W'($urandom);
            waitSig(1, 1'b0, 50, "ackFall", c);
        end else begin
            waitSig(0, 1'b1, 50, "validRiseViolation", c);
            req_i  = 1'b0;
            data_i = DATA_W'($urandom);
            repeat (LAT + 1) tick();
            checkOutput("errSetInValid", 32'(err_o), 32'd1);
            checkOutput("validHeldAfterDrop", 32'(valid_o), 32'd1);
            readyLevel = 1'b1;
            waitSig(2, 1'b0, 50, "idleAfterViolation", c);
            checkOutput("ackLowAfterViolation", 32'(ack_o), 32'd0);
        end
    endtask

    initial begin
        ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            ready_i = randReady ? 1'($urandom_range(0, 1)) : readyLevel;
        end
    end

    // Scoreboard monitor: data_o must match the oldest outstanding word every cycle valid_o is up.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                pendingAck = 1'b0;
                modelCount = 16'd0;
            end else begin
                if (pendingAck) begin
                    checkOutput("ackAfterAccept", 32'(ack_o), 32'd1);
                    checkOutput("xferCount", 32'(xfer_cnt_o), 32'(modelCount));
                    pendingAck = 1'b0;
                end
                if (valid_o) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedValid", 32'(valid_o), 32'd0);
                    end else begin
                        checkOutput("dataOut", 32'(data_o), 32'(expQ[0]));
                        checkOutput("ackLowWhileValid", 32'(ack_o), 32'd0);
                        if (ready_i) begin
                            void'(expQ.pop_front());
                            modelCount = modelCount + 16'd1;
                            pendingAck = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic doReset();
        rst_ni = 1'b0;
        req_i  = 1'b0;
        repeat (2) tick();
        rst_ni = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        int c;
        rst_ni = 1'b0;
        req_i  = 1'b0;
        data_i = '0;
        repeat (3) tick();
        checkOutput("resetValid", 32'(valid_o), 32'd0);
        checkOutput("resetAck", 32'(ack_o), 32'd0);
        checkOutput("resetBusy", 32'(busy_o), 32'd0);
        checkOutput("resetErr", 32'(err_o), 32'd0);
        checkOutput("resetCount", 32'(xfer_cnt_o), 32'd0);
        checkOutput("resetData", 32'(data_o), 32'd0);
        rst_ni = 1'b1;
        repeat (2) tick();

        // Basic transfer with latency measured in rising edges from req_i going high.
        expQ.push_back(8'hA5);
        data_i = 8'hA5;
        req_i  = 1'b1;
        waitSig(0, 1'b1, 20, "validRiseBasic", c);
        checkOutput("validLatency", 32'(c), 32'(LAT));
        checkOutput("dataBasic", 32'(data_o), 32'hA5);
        waitSig(1, 1'b1, 20, "ackRiseBasic", c);
        checkOutput("ackAfterValid", 32'(c), 32'd1);
        req_i = 1'b0;
        waitSig(1, 1'b0, 20, "ackFallBasic", c);
        checkOutput("ackFallLatency", 32'(c), 32'(LAT));
        checkOutput("countBasic", 32'(xfer_cnt_o), 32'd1);

        // Backpressure: word must sit unchanged with ack low until ready.
        readyLevel = 1'b0;
        repeat (2) tick();
        expQ.push_back(8'h3C);
        data_i = 8'h3C;
        req_i  = 1'b1;
        waitSig(0, 1'b1, 20, "validRiseBackpressure", c);
        repeat (10) tick();
        checkOutput("validHeld", 32'(valid_o), 32'd1);
        checkOutput("dataHeld", 32'(data_o), 32'h3C);
        checkOutput("ackLowBackpressure", 32'(ack_o), 32'd0);
        readyLevel = 1'b1;
        waitSig(1, 1'b1, 20, "ackRiseBackpressure", c);
        req_i = 1'b0;
        waitSig(1, 1'b0, 20, "ackFallBackpressure", c);
        checkOutput("countBackpressure", 32'(xfer_cnt_o), 32'd2);

        doReset();
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(DATA_W'(i), 1'b0);
        end
        checkOutput("countBackToBack", 32'(xfer_cnt_o), 32'd4);
        checkOutput("errBackToBack", 32'(err_o), 32'd0);

        randReady = 1'b1;
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            applyStimulus(DATA_W'($urandom), 1'b0);
        end
        randReady  = 1'b0;
        readyLevel = 1'b1;
        repeat (2) tick();
        checkOutput("countRandom", 32'(xfer_cnt_o), 32'd16);
        checkOutput("errRandom", 32'(err_o), 32'd0);

        readyLevel = 1'b0;
        repeat (2) tick();
        applyStimulus(8'h5A, 1'b1);
        checkOutput("countViolation", 32'(xfer_cnt_o), 32'd17);
        repeat (2) tick();
        applyStimulus(8'h77, 1'b0);
        checkOutput("errSticky", 32'(err_o), 32'd1);
        checkOutput("countAfterViolation", 32'(xfer_cnt_o), 32'd18);

        // Counter wrap: jump the counter to its maximum rather than running 65535 handshakes.
        force dut.xferCnt_q = 16'hFFFF;
        modelCount = 16'hFFFF;
        tick();
        release dut.xferCnt_q;
        tick();
        checkOutput("countPreload", 32'(xfer_cnt_o), 32'hFFFF);
        applyStimulus(8'hC3, 1'b0);
        checkOutput("countWrap", 32'(xfer_cnt_o), 32'h0000);

        // Reset while ack is high must clear every output with no clock edge.
        repeat (2) tick();
        expQ.push_back(8'h99);
        data_i = 8'h99;
        req_i  = 1'b1;
        waitSig(1, 1'b1, 30, "ackRiseMidReset", c);
        rst_ni = 1'b0;
        #2;
        checkOutput("asyncResetAck", 32'(ack_o), 32'd0);
        checkOutput("asyncResetValid", 32'(valid_o), 32'd0);
        checkOutput("asyncResetBusy", 32'(busy_o), 32'd0);
        checkOutput("asyncResetErr", 32'(err_o), 32'd0);
        checkOutput("asyncResetCount", 32'(xfer_cnt_o), 32'd0);
        checkOutput("asyncResetData", 32'(data_o), 32'd0);
        req_i = 1'b0;
        repeat (2) tick();
        rst_ni = 1'b1;
        repeat (LAT + 2) tick();
        checkOutput("idleAfterReset", 32'(busy_o), 32'd0);
        checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
